// File: rtl/hazard_ctrl.sv
// Hazard and bypass controller for an in-order pipeline of DEPTH stages.
// Tracks in-flight writers, issues registered bypass selects, load-use stalls and redirect kills.
module hazard_ctrl #(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int AW       = 5,
    parameter int CNT_W    = 16,
    localparam int FW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic             x_redirect,
    output logic             stall,
    output logic [FW-1:0]    fwd_a,
    output logic [FW-1:0]    fwd_b,
    output logic             x_valid,
    output logic             rf_we,
    output logic [CNT_W-1:0] stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Scoreboard entry k describes the instruction currently in stage Sk.
    logic [DEPTH-1:1] ent_v;
    logic [DEPTH-1:1] ent_we;
    logic [DEPTH-1:1] ent_ld;
    logic [AW-1:0]    ent_rd [1:DEPTH-1];

    logic [FW-1:0]    sel_a, sel_b;
    logic             busy_a, busy_b;
    logic             accept;
    logic [FW-1:0]    fwd_a_p1, fwd_b_p1;
    logic             rf_we_p1;
    logic [CNT_W-1:0] cnt_p1;

    // Walk oldest to youngest so the youngest producer overrides older ones.
    always_comb begin
        sel_a  = '0;
        busy_a = 1'b0;
        sel_b  = '0;
        busy_b = 1'b0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (ent_v[k] && ent_we[k] && (ent_rd[k] == id_rs1) &&
                (id_rs1 != '0) && id_rs1_used) begin
                sel_a  = FW'(k + 1);
                busy_a = ent_ld[k] && (k < 1 + LOAD_LAT);
            end
            if (ent_v[k] && ent_we[k] && (ent_rd[k] == id_rs2) &&
                (id_rs2 != '0) && id_rs2_used) begin
                sel_b  = FW'(k + 1);
                busy_b = ent_ld[k] && (k < 1 + LOAD_LAT);
            end
        end
    end

    // A redirect kills the S0 instruction, so it never also stalls.
    assign stall  = reset & id_valid & ~x_redirect & (busy_a | busy_b);
    assign accept = id_valid & ~stall & ~x_redirect;

    // S0 -> S1 boundary: control state, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_v    <= '0;
            fwd_a_p1 <= '0;
            fwd_b_p1 <= '0;
            rf_we_p1 <= 1'b0;
            cnt_p1   <= '0;
        end else begin
            ent_v    <= {ent_v[DEPTH-2:1], accept};
            fwd_a_p1 <= accept ? sel_a : '0;
            fwd_b_p1 <= accept ? sel_b : '0;
            rf_we_p1 <= ent_v[DEPTH-2] & ent_we[DEPTH-2] & (ent_rd[DEPTH-2] != '0);
            if (stall) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

    // Entry payload is only meaningful under ent_v, so it carries no reset.
    always_ff @(posedge clk) begin
        ent_we <= {ent_we[DEPTH-2:1], id_rd_we};
        ent_ld <= {ent_ld[DEPTH-2:1], id_is_load};
        ent_rd[1] <= id_rd;
        for (int k = 2; k <= DEPTH - 1; k++) begin
            ent_rd[k] <= ent_rd[k-1];
        end
    end

    assign fwd_a     = fwd_a_p1;
    assign fwd_b     = fwd_b_p1;
    assign x_valid   = ent_v[1];
    assign rf_we     = rf_we_p1;
    assign stall_cnt = cnt_p1;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: DEPTH=3/LOAD_LAT=1 instance plus a DEPTH=5/LOAD_LAT=2/CNT_W=4 instance.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_rd_we, id_is_load, x_redirect;

    logic        a_stall, a_x_valid, a_rf_we;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic [15:0] a_cnt;
    logic        b_stall, b_x_valid, b_rf_we;
    logic [2:0]  b_fwd_a, b_fwd_b;
    logic [3:0]  b_cnt;

    hazard_ctrl #(.DEPTH(3), .LOAD_LAT(1), .AW(5), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .x_redirect(x_redirect), .stall(a_stall),
        .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .x_valid(a_x_valid),
        .rf_we(a_rf_we), .stall_cnt(a_cnt)
    );

    hazard_ctrl #(.DEPTH(5), .LOAD_LAT(2), .AW(5), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .x_redirect(x_redirect), .stall(b_stall),
        .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .x_valid(b_x_valid),
        .rf_we(b_rf_we), .stall_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int F_STALL = 0, F_FWDA = 1, F_FWDB = 2, F_XV = 3, F_RFWE = 4, F_CNT = 5;

    typedef struct {
        int    cyc;
        int    sel;
        int    fld;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_total  = 0;
    int   n_pass   = 0;

    function automatic int act_val(int sel, int fld);
        if (sel == 0) begin
            case (fld)
                F_STALL: return int'(a_stall);
                F_FWDA:  return int'(a_fwd_a);
                F_FWDB:  return int'(a_fwd_b);
                F_XV:    return int'(a_x_valid);
                F_RFWE:  return int'(a_rf_we);
                default: return int'(a_cnt);
            endcase
        end
        case (fld)
            F_STALL: return int'(b_stall);
            F_FWDA:  return int'(b_fwd_a);
            F_FWDB:  return int'(b_fwd_b);
            F_XV:    return int'(b_x_valid);
            F_RFWE:  return int'(b_rf_we);
            default: return int'(b_cnt);
        endcase
    endfunction

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            int   got;
            e   = sb.pop_front();
            got = act_val(e.sel, e.fld);
            n_total++;
            if (e.cyc == cyc && got == e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %0d want %0d (cycle %0d, seen at %0d)",
                         e.name, got, e.val, e.cyc, cyc);
            end
        end
    end

    task automatic chk(input string nm, input int sel, input int fld, input int val);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.fld  = fld;
        e.val  = val;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic v, input int r1, input logic u1, input int r2,
                        input logic u2, input int rd, input logic we, input logic ld,
                        input logic rdr);
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rs1      = 5'(r1);
        id_rs1_used = u1;
        id_rs2      = 5'(r2);
        id_rs2_used = u2;
        id_rd       = 5'(rd);
        id_rd_we    = we;
        id_is_load  = ld;
        x_redirect  = rdr;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input int rd);
        step(1'b1, 0, 1'b0, 0, 1'b0, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic lw(input int rd);
        step(1'b1, 0, 1'b0, 0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_we = 1'b0;
        id_is_load = 1'b0; x_redirect = 1'b0;

        // Held in reset with a would-be hazard on the inputs.
        step(1'b1, 5, 1'b1, 5, 1'b1, 5, 1'b1, 1'b1, 1'b0);
        chk("rst_stall", 0, F_STALL, 0);
        chk("rst_fwd_a", 0, F_FWDA, 0);
        chk("rst_fwd_b", 0, F_FWDB, 0);
        chk("rst_x_valid", 0, F_XV, 0);
        chk("rst_rf_we", 0, F_RFWE, 0);
        chk("rst_cnt", 0, F_CNT, 0);
        step(1'b1, 5, 1'b1, 5, 1'b1, 5, 1'b1, 1'b1, 1'b0);
        chk("rst_hold_stall", 0, F_STALL, 0);
        chk("rst_hold_x_valid", 0, F_XV, 0);
        idle();
        rst_n = 1'b1;

        // ALU back-to-back: x5 then add x6,x5,x5.
        wr(5);
        chk("b2b_prod_stall", 0, F_STALL, 0);
        step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0);
        chk("b2b_cons_stall", 0, F_STALL, 0);
        chk("b2b_prod_x_valid", 0, F_XV, 1);
        chk("b2b_rf_we_early", 0, F_RFWE, 0);
        idle();
        chk("b2b_fwd_a", 0, F_FWDA, 2);
        chk("b2b_fwd_b", 0, F_FWDB, 2);
        chk("b2b_cons_x_valid", 0, F_XV, 1);
        chk("first_rf_we", 0, F_RFWE, 1);
        idle();
        chk("b2b_idle_fwd_a", 0, F_FWDA, 0);
        chk("b2b_cons_rf_we", 0, F_RFWE, 1);

        // Distance 2 selects the hold register.
        wr(5);
        idle();
        step(1'b1, 5, 1'b1, 0, 1'b1, 10, 1'b1, 1'b0, 1'b0);
        idle();
        chk("dist2_fwd_a", 0, F_FWDA, 3);
        chk("dist2_fwd_b", 0, F_FWDB, 0);

        // Distance 3 reads the regfile.
        wr(5);
        idle();
        idle();
        step(1'b1, 5, 1'b1, 0, 1'b0, 10, 1'b1, 1'b0, 1'b0);
        idle();
        chk("dist3_fwd_a", 0, F_FWDA, 0);
        chk("dist3_x_valid", 0, F_XV, 1);

        // Load-use: lw x7 ; add x8,x7,x0.
        lw(7);
        step(1'b1, 7, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        chk("lu_stall", 0, F_STALL, 1);
        step(1'b1, 7, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        chk("lu_stall_end", 0, F_STALL, 0);
        chk("lu_bubble", 0, F_XV, 0);
        chk("lu_cnt_mid", 0, F_CNT, 1);
        idle();
        chk("lu_fwd_a", 0, F_FWDA, 3);
        chk("lu_fwd_b", 0, F_FWDB, 0);
        chk("lu_x_valid", 0, F_XV, 1);
        chk("lu_cnt", 0, F_CNT, 1);

        // Youngest producer wins.
        wr(5);
        wr(5);
        step(1'b1, 5, 1'b1, 0, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        chk("young_stall", 0, F_STALL, 0);
        idle();
        chk("young_fwd_a", 0, F_FWDA, 2);
        chk("young_fwd_b", 0, F_FWDB, 0);

        // x0 writer then x0 reader.
        wr(0);
        step(1'b1, 0, 1'b1, 0, 1'b1, 11, 1'b1, 1'b0, 1'b0);
        idle();
        chk("x0_fwd_a", 0, F_FWDA, 0);
        chk("x0_fwd_b", 0, F_FWDB, 0);
        chk("x0_x_valid", 0, F_XV, 1);
        chk("x0_rf_we", 0, F_RFWE, 0);

        // Redirect beats a pending load-use stall.
        lw(7);
        step(1'b1, 7, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0, 1'b1);
        chk("redir_stall", 0, F_STALL, 0);
        idle();
        chk("redir_x_valid", 0, F_XV, 0);
        chk("redir_fwd_a", 0, F_FWDA, 0);
        chk("redir_cnt", 0, F_CNT, 1);

        // Reset asserted mid-stall.
        lw(7);
        step(1'b1, 7, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        chk("rstmid_stall", 0, F_STALL, 0);
        chk("rstmid_x_valid", 0, F_XV, 0);
        chk("rstmid_cnt", 0, F_CNT, 0);
        idle();
        rst_n = 1'b1;
        chk("rstmid_rf_we", 0, F_RFWE, 0);
        chk("rstmid_x_valid2", 0, F_XV, 0);
        step(1'b1, 7, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        chk("rstmid_no_match", 0, F_STALL, 0);

        // DEPTH=5, LOAD_LAT=2: load-use stalls two cycles, then fwd=4.
        lw(7);
        step(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        chk("p_stall1", 1, F_STALL, 1);
        step(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        chk("p_stall2", 1, F_STALL, 1);
        step(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        chk("p_stall3", 1, F_STALL, 0);
        idle();
        chk("p_fwd_a", 1, F_FWDA, 4);
        chk("p_fwd_b", 1, F_FWDB, 0);
        chk("p_x_valid", 1, F_XV, 1);
        chk("p_cnt", 1, F_CNT, 2);
        chk("p_rf_we", 1, F_RFWE, 1);

        // Drive the 4-bit counter well past all-ones.
        for (int i = 0; i < 10; i++) begin
            lw(7);
            step(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
            step(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
            step(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        end
        idle();
        chk("sat_cnt", 1, F_CNT, 15);
        lw(7);
        step(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        chk("sat_stall", 1, F_STALL, 1);
        idle();
        chk("sat_hold", 1, F_CNT, 15);

        idle();
        idle();
        @(negedge clk);
        #1;
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
